// File: rtl/lfsr_prng.sv
// lfsr_prng: parametrised Fibonacci LFSR word generator with a valid/ready output.
// The LFSR shifts left and the feedback (parity of state & TAPS) enters bit 0.
// Each output word is taken after STEPS shifts. The generator holds the word
// until the consumer accepts it.
// Optional feature: define LFSR_WRAP_DET_EN to add a stored-seed register.
// With it, wrap_o pulses when the sequence returns to the last loaded seed.
// Without it, wrap_o is tied to 0.
module lfsr_prng #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h088C_8892),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'h00BC_3328),
  parameter int               OUT_W = 32,
  parameter int               STEPS = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic [OUT_W-1:0] word_o,
  output logic [WIDTH-1:0] state_o,
  output logic             wrap_o
);

  typedef enum logic {FILL, VALID} fsm_t;

  localparam logic [7:0] LAST_STEP = 8'(STEPS - 1);

  fsm_t             fsm;
  logic [7:0]       step_cnt;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] load_value;

  assign next_state = {state[WIDTH-2:0], ^(state & TAPS)};
  // A zero seed would lock the LFSR at zero, so it falls back to SEED.
  assign load_value = (seed_i == '0) ? SEED : seed_i;
  assign state_o    = state;

  // State, step counter, FSM and the registered word/valid outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= SEED;
      step_cnt     <= '0;
      fsm          <= FILL;
      word_valid_o <= 1'b0;
      word_o       <= '0;
    end else if (seed_load_i) begin
      // A reseed discards any partial word.
      // A handshake in this cycle still counts as taken.
      state        <= load_value;
      step_cnt     <= '0;
      fsm          <= FILL;
      word_valid_o <= 1'b0;
    end else begin
      case (fsm)
        FILL: begin
          if (en_i) begin
            state <= next_state;
            if (step_cnt == LAST_STEP) begin
              step_cnt     <= '0;
              word_o       <= next_state[OUT_W-1:0];
              word_valid_o <= 1'b1;
              fsm          <= VALID;
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
        end
        VALID: begin
          // The word is frozen until accepted; no step in the handshake cycle.
          if (word_ready_i) begin
            word_valid_o <= 1'b0;
            fsm          <= FILL;
          end
        end
        default: fsm <= FILL;
      endcase
    end
  end

`ifdef LFSR_WRAP_DET_EN
  logic [WIDTH-1:0] seed_reg;
  logic             step_fire;

  assign step_fire = !seed_load_i && (fsm == FILL) && en_i;

  // Remember the last seed; flag the step that lands back on it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      seed_reg <= SEED;
      wrap_o   <= 1'b0;
    end else if (seed_load_i) begin
      seed_reg <= load_value;
      wrap_o   <= 1'b0;
    end else begin
      wrap_o <= step_fire && (next_state == seed_reg);
    end
  end
`else
  assign wrap_o = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// tb_lfsr_prng: scoreboard bench for lfsr_prng.
// It uses three instances:
//   a: STEPS=1
//   b: STEPS=4
//   c: 4-bit wrap instance
module tb_lfsr_prng;

  localparam logic [31:0] SEED32 = 32'h00BC_3328;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        a_en, a_load, a_valid, a_ready, a_wrap;
  logic [31:0] a_seed, a_word, a_state;
  logic        b_en, b_load, b_valid, b_ready, b_wrap;
  logic [31:0] b_seed, b_word, b_state;
  logic        c_en, c_load, c_valid, c_ready, c_wrap;
  logic [3:0]  c_seed, c_word, c_state;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  lfsr_prng #(.STEPS(1)) u_a (
    .clk_i(clk), .reset_i(reset), .en_i(a_en), .seed_load_i(a_load), .seed_i(a_seed),
    .word_valid_o(a_valid), .word_ready_i(a_ready), .word_o(a_word), .state_o(a_state),
    .wrap_o(a_wrap));

  lfsr_prng #(.STEPS(4)) u_b (
    .clk_i(clk), .reset_i(reset), .en_i(b_en), .seed_load_i(b_load), .seed_i(b_seed),
    .word_valid_o(b_valid), .word_ready_i(b_ready), .word_o(b_word), .state_o(b_state),
    .wrap_o(b_wrap));

  lfsr_prng #(.WIDTH(4), .TAPS(4'h9), .SEED(4'h1), .OUT_W(4), .STEPS(1)) u_c (
    .clk_i(clk), .reset_i(reset), .en_i(c_en), .seed_load_i(c_load), .seed_i(c_seed),
    .word_valid_o(c_valid), .word_ready_i(c_ready), .word_o(c_word), .state_o(c_state),
    .wrap_o(c_wrap));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] step32(input logic [31:0] s);
    return {s[30:0], ^(s & 32'h088C_8892)};
  endfunction

  function automatic logic [31:0] stepn32(input logic [31:0] s, input int n);
    logic [31:0] r = s;
    for (int i = 0; i < n; i++) r = step32(r);
    return r;
  endfunction

  // Taps 4'h9: feedback = bit3 ^ bit0.
  function automatic logic [3:0] step4(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[0]};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Accepted words are compared against the scoreboard queues.
  always @(negedge clk) begin
    if (!reset && a_valid && a_ready) begin
      check("a_sb_depth", 64'(qa.size() > 0), 64'(1));
      if (qa.size() > 0) check("a_sb_word", 64'(a_word), 64'(qa.pop_front()));
    end
    if (!reset && b_valid && b_ready) begin
      check("b_sb_depth", 64'(qb.size() > 0), 64'(1));
      if (qb.size() > 0) check("b_sb_word", 64'(b_word), 64'(qb.pop_front()));
    end
  end

  initial begin
    logic [31:0] w;
    logic [3:0]  m;
    logic [3:0]  prev;
    logic [15:0] seen;
    int          n, steps, wraps, zeros;

    reset = 1'b1;
    {a_en, a_load, a_ready, b_en, b_load, b_ready, c_en, c_load, c_ready} = '0;
    a_seed = '0; b_seed = '0; c_seed = '0;
    tick(2);

    check("a_rst_state", 64'(a_state), 64'(SEED32));
    check("a_rst_valid", 64'(a_valid), 64'(0));
    check("a_rst_word",  64'(a_word),  64'(0));
    check("a_rst_wrap",  64'(a_wrap),  64'(0));
    check("b_rst_valid", 64'(b_valid), 64'(0));
    check("c_rst_state", 64'(c_state), 64'(1));

    // First word, then hold ready low for 10 cycles.
    a_en = 1'b1;
    w = step32(SEED32);
    qa.push_back(w);
    reset = 1'b0;
    tick();
    check("a_first_valid", 64'(a_valid), 64'(1));
    check("a_first_word",  64'(a_word),  64'(32'h0178_6651));
    check("a_first_state", 64'(a_state), 64'(32'h0178_6651));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("a_hold_valid", 64'(a_valid), 64'(1));
      check("a_hold_word",  64'(a_word),  64'(32'h0178_6651));
      check("a_hold_state", 64'(a_state), 64'(32'h0178_6651));
    end
    a_ready = 1'b1;
    tick();
    check("a_drop_valid", 64'(a_valid), 64'(0));
    check("a_hs_nostep",  64'(a_state), 64'(32'h0178_6651));

    // Free-running stream at ready=1.
    for (int k = 0; k < 3; k++) begin
      w = step32(w);
      qa.push_back(w);
    end
    tick(6);
    a_en = 1'b0;
    a_ready = 1'b0;

    // Zero seed falls back to SEED; word_o keeps its old value.
    a_load = 1'b1;
    a_seed = '0;
    tick();
    check("a_zero_seed", 64'(a_state), 64'(SEED32));
    check("a_load_valid", 64'(a_valid), 64'(0));
    check("a_load_word", 64'(a_word), 64'(w));
    a_seed = 32'h1;
    tick();
    check("a_seed1", 64'(a_state), 64'(1));
    a_load = 1'b0;
    a_en = 1'b1;
    qa.push_back(32'h2);
    tick();
    check("a_seed1_step", 64'(a_state), 64'(2));
    check("a_seed1_valid", 64'(a_valid), 64'(1));

    // Reseed in the same cycle as a handshake.
    a_en = 1'b0;
    a_ready = 1'b1;
    a_load = 1'b1;
    a_seed = 32'h1234_5678;
    tick();
    check("a_hsload_valid", 64'(a_valid), 64'(0));
    check("a_hsload_state", 64'(a_state), 64'(32'h1234_5678));
    check("a_hsload_word",  64'(a_word),  64'(2));
    a_load = 1'b0;
    a_ready = 1'b0;
    a_en = 1'b1;
    qa.push_back(step32(32'h1234_5678));
    tick();
    check("a_after_load_valid", 64'(a_valid), 64'(1));
    a_ready = 1'b1;
    tick();
    check("a_after_load_drop", 64'(a_valid), 64'(0));
    a_ready = 1'b0;
    tick();

    // Asynchronous mid-operation reset: takes effect before the next edge.
    #2 reset = 1'b1;
    #1;
    check("a_async_valid", 64'(a_valid), 64'(0));
    check("a_async_state", 64'(a_state), 64'(SEED32));
    check("a_async_word",  64'(a_word),  64'(0));
    a_en = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Toggle enable for STEPS=4, starting with en low.
    qb.push_back(stepn32(SEED32, 4));
    for (int i = 1; i <= 8; i++) begin
      b_en = (i % 2 == 0);
      tick();
      if (i == 7) check("b_toggle_early", 64'(b_valid), 64'(0));
    end
    check("b_toggle_valid", 64'(b_valid), 64'(1));
    check("b_toggle_word",  64'(b_word),  64'(stepn32(SEED32, 4)));
    check("b_toggle_state", 64'(b_state), 64'(stepn32(SEED32, 4)));
    b_ready = 1'b1;
    tick();
    check("b_drop", 64'(b_valid), 64'(0));

    // Reseed mid-FILL aborts the partial word.
    b_en = 1'b1;
    tick(2);
    check("b_partial", 64'(b_state), 64'(stepn32(SEED32, 6)));
    b_load = 1'b1;
    b_seed = 32'hCAFE_BABE;
    tick();
    b_load = 1'b0;
    check("b_reload_state", 64'(b_state), 64'(32'hCAFE_BABE));
    check("b_reload_valid", 64'(b_valid), 64'(0));
    qb.push_back(stepn32(32'hCAFE_BABE, 4));
    n = 0;
    while (!b_valid && n < 20) begin
      tick();
      n++;
    end
    check("b_reload_latency", 64'(n), 64'(4));
    tick();
    b_en = 1'b0;
    b_ready = 1'b0;

    // 4-bit period: 15 distinct nonzero states and a wrap every 15 steps.
    c_en = 1'b1;
    c_ready = 1'b1;
    seen = '0;
    steps = 0;
    wraps = 0;
    zeros = 0;
    m = 4'h1;
    prev = c_state;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (c_state != prev) begin
        steps++;
        m = step4(m);
        check("c_seq", 64'(c_state), 64'(m));
        if (steps <= 15) seen[c_state] = 1'b1;
        prev = c_state;
      end
      if (c_state == 4'h0) zeros++;
      if (c_wrap) begin
        wraps++;
        check("c_wrap_at_seed", 64'(c_state), 64'(1));
      end
    end
    check("c_steps",    64'(steps),            64'(30));
    check("c_distinct", 64'($countones(seen)), 64'(15));
    check("c_zero",     64'(zeros),            64'(0));
`ifdef LFSR_WRAP_DET_EN
    check("c_wraps", 64'(wraps), 64'(2));
`else
    check("c_wraps", 64'(wraps), 64'(0));
`endif

    check("a_sb_left", 64'(qa.size()), 64'(0));
    check("b_sb_left", 64'(qb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
